dpram_fifo_ctrl: RTL and testbench
==================================

# dpram_fifo_ctrl

Single-clock synchronous FIFO controller that drives both ports of an external `dpram_r2w1_hl` instance.
- Port A is the write port; port B is the read port.
- Exposes valid/ready push and pop streams with first-word-fall-through output.
- Sits directly upstream of the RAM: it owns all RAM address, enable and select lines, and consumes `b_read`.

## Interface
- `ADDR_W`, 9, RAM address width; RAM depth is `DEPTH = 2**ADDR_W`.
- `DATA_W`, 16, word width.
- `AF_TH`, 448, almost-full threshold on `level`.
- `clk`  in  1  clock; the integrator also ties `a_clk` and `b_clk` of the RAM to it.
- `reset_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  push request.
- `in_ready`  out  1  push accepted when high together with `in_valid`.
- `in_data`  in  DATA_W  push word.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  pop when high together with `out_valid`.
- `out_data`  out  DATA_W  head word.
- `level`  out  ADDR_W+2  total words held (RAM plus in-flight read plus output buffer).
- `almost_full`  out  1  `level >= AF_TH`.
- `a_addr`, `a_sel`, `a_write`, `a_we`, `a_ce`  out  ADDR_W/2/DATA_W/1/1  RAM port A.
- `b_addr`, `b_sel`, `b_we`, `b_ce`  out  ADDR_W/2/1/1  RAM port B.
- `b_read`  in  DATA_W  RAM port B read data, registered, 1-cycle latency.
- `flush`  in  1  present only with `DPRAM_FIFO_FLUSH_EN`.

## Operation
- Reset: all pointers, counts and buffers are cleared.
- Reset values of outputs:
  - `in_ready = 1`
  - `out_valid = 0`
  - `out_data = 0`
  - `level = 0`
  - `almost_full = 0`
  - all RAM enables `0`; all RAM addresses `0`
  - `a_sel` and `b_sel` are constant `2'b11`; `b_we` is constant `0`.
- Push:
  - A push is the event `in_valid & in_ready`.
  - It drives `a_ce = a_we = 1`, `a_addr = wptr`, `a_write = in_data` combinationally.
  - `wptr` increments modulo DEPTH.
- `in_ready` is `mem_cnt < DEPTH`. `mem_cnt` counts words resident in RAM and not yet requested for reading.
- Read issue:
  - A read is issued when `mem_cnt > 0` and `(ob_cnt + inflight - pop) < 2`.
  - `ob_cnt` is the output buffer occupancy, 0..2; `inflight` is 0..1; `pop` is the pop event this cycle.
  - Issuing drives `b_ce = 1`, `b_addr = rptr`; `rptr` increments modulo DEPTH.
  - `mem_cnt` decrements, or stays unchanged on a simultaneous push.
- Read return: the cycle after issue, `b_read` is written into the 2-entry output buffer.
- Output: `out_data` is the buffer head; `out_valid = (ob_cnt != 0)`.
- Pop: `out_valid & out_ready` removes the head.
- Simultaneous events, all in one cycle:
  - push on full is refused;
  - push + read issue + return + pop are all legal;
  - `level` changes by `push − pop`.
- No read ever targets an address written in the same cycle, so the RAM's read-during-write mode is irrelevant.
- `almost_full` is registered from the next-state `level`.

## Timing
- Empty to visible:
  - push accepted at edge k;
  - read issued in the cycle after k;
  - data returns after edge k+1;
  - `out_valid = 1` after edge k+2.
- Sustained throughput is 1 push and 1 pop per cycle with `out_ready` held high, no bubbles once primed.
- Full: `in_ready` falls after the edge that writes the DEPTH-th RAM-resident word.
  - Max `level` is DEPTH+2 (RAM full plus buffer full).
- `out_ready` low: the buffer fills to 2, issue stops, RAM fills, then `in_ready = 0`.
- `reset_n` asserted mid-transfer: everything clears immediately, including any in-flight read, and the next `b_read` is ignored.
  - Deassertion is synchronised by the integrator.

## Configuration
- `DPRAM_FIFO_FLUSH_EN` defined:
  - adds the `flush` input;
  - `flush = 1` at an edge clears pointers, counts, buffer and in-flight read, with the same result as reset;
  - any push or pop in that cycle is discarded;
  - `in_ready = 1` and `out_valid = 0` from the next cycle.
- Not defined: no `flush` port; the FIFO empties only by pops or reset.

## Test plan
- Single word: push `0xA5A5` at edge k with `out_ready = 1` -> `out_valid` rises after k+2 with `out_data = 0xA5A5`, then `level` returns to 0.
- Fill: `out_ready = 0`, push 0..0x201 -> all 514 accepted, `in_ready = 0`, `level = 514`, `almost_full = 1`; the 515th push is refused.
- Streaming: 2000 consecutive pushes with `out_ready = 1` -> pops come out in order, one per cycle after a 3-cycle prime, no loss across pointer wrap at 511->0.
- Random backpressure: random `in_valid`/`out_ready` for 10000 cycles -> scoreboard order matches, `level` always equals pushes minus pops.
- Reset mid-stream: assert `reset_n = 0` with `level = 37` and a read in flight -> all outputs at reset values, and the next push of `0x1234` is the first word popped.
- Flush (`DPRAM_FIFO_FLUSH_EN`): `flush` pulse at `level = 100` during a push -> `level = 0` next cycle, and the pushed word is not output.

Source files
------------

// File: rtl/dpram_fifo_ctrl.sv
// FWFT FIFO controller driving an external dpram_r2w1_hl: port A writes, port B reads.
// Defining DPRAM_FIFO_FLUSH_EN adds a synchronous flush input that behaves like reset.
module dpram_fifo_ctrl #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned AF_TH  = 448
) (
    input  logic                clk,
    input  logic                reset_n,
`ifdef DPRAM_FIFO_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ADDR_W+1:0]   level,
    output logic                almost_full,
    output logic [ADDR_W-1:0]   a_addr,
    output logic [1:0]          a_sel,
    output logic [DATA_W-1:0]   a_write,
    output logic                a_we,
    output logic                a_ce,
    output logic [ADDR_W-1:0]   b_addr,
    output logic [1:0]          b_sel,
    output logic                b_we,
    output logic                b_ce,
    input  logic [DATA_W-1:0]   b_read
);

    localparam int unsigned     DEPTH    = 2**ADDR_W;
    localparam int unsigned     LEVEL_W  = ADDR_W + 2;
    localparam logic [ADDR_W:0] MEM_FULL = (ADDR_W+1)'(DEPTH);

    logic                clr;
    logic                push;
    logic                pop;
    logic                issue;
    logic [2:0]          pend;
    logic [ADDR_W-1:0]   wptr;
    logic [ADDR_W-1:0]   rptr;
    logic [ADDR_W-1:0]   wptr_nxt;
    logic [ADDR_W-1:0]   rptr_nxt;
    logic [ADDR_W:0]     mem_cnt;
    logic [ADDR_W:0]     mem_cnt_nxt;
    logic [1:0]          ob_cnt;
    logic [1:0]          ob_cnt_nxt;
    logic [1:0]          wr_idx;
    logic                inflight;
    logic                inflight_nxt;
    logic [DATA_W-1:0]   ob_data     [2];
    logic [DATA_W-1:0]   ob_data_nxt [2];
    logic [LEVEL_W-1:0]  level_nxt;

`ifdef DPRAM_FIFO_FLUSH_EN
    assign clr = flush;
`else
    assign clr = 1'b0;
`endif

    assign in_ready  = (mem_cnt < MEM_FULL);
    assign out_valid = (ob_cnt != '0);
    assign out_data  = ob_data[0];

    assign push = in_valid & in_ready & ~clr;
    assign pop  = out_valid & out_ready & ~clr;

    // Issue only if the returning word is guaranteed a buffer slot next cycle.
    always_comb begin
        pend  = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop};
        issue = (mem_cnt != '0) && (pend < 3'd2) && !clr;
    end

    assign a_ce    = push;
    assign a_we    = push;
    assign a_addr  = wptr;
    assign a_write = in_data;
    assign a_sel   = 2'b11;
    assign b_ce    = issue;
    assign b_addr  = rptr;
    assign b_we    = 1'b0;
    assign b_sel   = 2'b11;

    always_comb begin
        wptr_nxt     = push  ? wptr + ADDR_W'(1) : wptr;
        rptr_nxt     = issue ? rptr + ADDR_W'(1) : rptr;
        inflight_nxt = issue;

        case ({push, issue})
            2'b10:   mem_cnt_nxt = mem_cnt + (ADDR_W+1)'(1);
            2'b01:   mem_cnt_nxt = mem_cnt - (ADDR_W+1)'(1);
            default: mem_cnt_nxt = mem_cnt;
        endcase

        case ({inflight, pop})
            2'b10:   ob_cnt_nxt = ob_cnt + 2'd1;
            2'b01:   ob_cnt_nxt = ob_cnt - 2'd1;
            default: ob_cnt_nxt = ob_cnt;
        endcase

        case ({push, pop})
            2'b10:   level_nxt = level + LEVEL_W'(1);
            2'b01:   level_nxt = level - LEVEL_W'(1);
            default: level_nxt = level;
        endcase

        // Returning word lands behind whatever survives this cycle's pop.
        wr_idx         = ob_cnt - {1'b0, pop};
        ob_data_nxt[0] = ob_data[0];
        ob_data_nxt[1] = ob_data[1];
        if (pop) begin
            ob_data_nxt[0] = ob_data[1];
        end
        if (inflight) begin
            if (wr_idx == 2'd0) begin
                ob_data_nxt[0] = b_read;
            end else begin
                ob_data_nxt[1] = b_read;
            end
        end

        if (clr) begin
            wptr_nxt       = '0;
            rptr_nxt       = '0;
            inflight_nxt   = 1'b0;
            mem_cnt_nxt    = '0;
            ob_cnt_nxt     = '0;
            level_nxt      = '0;
            ob_data_nxt[0] = '0;
            ob_data_nxt[1] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr        <= '0;
            rptr        <= '0;
            mem_cnt     <= '0;
            ob_cnt      <= '0;
            inflight    <= 1'b0;
            ob_data[0]  <= '0;
            ob_data[1]  <= '0;
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            wptr        <= wptr_nxt;
            rptr        <= rptr_nxt;
            mem_cnt     <= mem_cnt_nxt;
            ob_cnt      <= ob_cnt_nxt;
            inflight    <= inflight_nxt;
            ob_data[0]  <= ob_data_nxt[0];
            ob_data[1]  <= ob_data_nxt[1];
            level       <= level_nxt;
            almost_full <= (level_nxt >= LEVEL_W'(AF_TH));
        end
    end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural RAM; flush test runs when DPRAM_FIFO_FLUSH_EN is defined.
module tb_dpram_fifo_ctrl;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned AF_TH  = 448;
    localparam int unsigned DEPTH  = 2**ADDR_W;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
`ifdef DPRAM_FIFO_FLUSH_EN
    logic                flush = 1'b0;
`endif
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_W-1:0]   in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [DATA_W-1:0]   out_data;
    logic [ADDR_W+1:0]   level;
    logic                almost_full;
    logic [ADDR_W-1:0]   a_addr;
    logic [1:0]          a_sel;
    logic [DATA_W-1:0]   a_write;
    logic                a_we;
    logic                a_ce;
    logic [ADDR_W-1:0]   b_addr;
    logic [1:0]          b_sel;
    logic                b_we;
    logic                b_ce;
    logic [DATA_W-1:0]   b_read = '0;

    logic [DATA_W-1:0]   ram [DEPTH];
    logic [DATA_W-1:0]   exp_q [$];
    int                  model_level = 0;
    int                  n_checks = 0;
    int                  n_fail = 0;

    dpram_fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AF_TH(AF_TH)) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef DPRAM_FIFO_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .level(level),
        .almost_full(almost_full),
        .a_addr(a_addr),
        .a_sel(a_sel),
        .a_write(a_write),
        .a_we(a_we),
        .a_ce(a_ce),
        .b_addr(b_addr),
        .b_sel(b_sel),
        .b_we(b_we),
        .b_ce(b_ce),
        .b_read(b_read)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the dual-port RAM: registered read, 1-cycle latency.
    always @(posedge clk) begin
        if (a_ce && a_we) ram[a_addr] <= a_write;
        if (b_ce) b_read <= ram[b_addr];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (v && in_ready) exp_q.push_back(d);
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            cyc();
            drive(1'b0, '0, 1'b1);
            k++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (2) cyc();
        check("drain_level", level, 0);
    endtask

    // Monitor: counts handshakes for the level model and checks popped words in order.
    always @(negedge clk) begin
        logic [DATA_W-1:0] e;
        if (!reset_n) begin
            model_level = 0;
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_data", out_data, 0);
            check("rst_level", level, 0);
            check("rst_almost_full", almost_full, 0);
            check("rst_enables", {a_ce, a_we, b_ce, b_we}, 0);
            check("rst_addrs", {a_addr, b_addr}, 0);
            check("rst_sel", {a_sel, b_sel}, 4'hF);
        end else begin
            check("level", level, model_level);
            check("almost_full", almost_full, (model_level >= int'(AF_TH)));
`ifdef DPRAM_FIFO_FLUSH_EN
            if (flush) begin
                model_level = 0;
            end else
`endif
            begin
                if (in_valid && in_ready) model_level++;
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL pop_unexpected: got 0x%0h expected no word", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            n_fail++;
                            $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_data, e);
                        end
                    end
                    model_level--;
                end
            end
        end
    end

    initial begin
        repeat (3) cyc();
        reset_n = 1'b1;

        // Single word latency
        cyc();
        drive(1'b1, 16'hA5A5, 1'b1);
        cyc();
        check("sw_valid_k", out_valid, 0);
        check("sw_level_k", level, 1);
        check("sw_issue", b_ce, 1);
        check("sw_issue_addr", b_addr, 0);
        drive(1'b0, '0, 1'b1);
        cyc();
        check("sw_valid_k1", out_valid, 0);
        cyc();
        check("sw_valid_k2", out_valid, 1);
        check("sw_data", out_data, 16'hA5A5);
        cyc();
        check("sw_level_end", level, 0);
        drain();

        // Fill with output stalled
        for (int i = 0; i < DEPTH + 2; i++) begin
            cyc();
            check("fill_ready", in_ready, 1);
            drive(1'b1, DATA_W'(i), 1'b0);
        end
        cyc();
        check("full_ready", in_ready, 0);
        check("full_level", level, DEPTH + 2);
        check("full_af", almost_full, 1);
        drive(1'b1, 16'h0202, 1'b0);
        cyc();
        check("full_refused", level, DEPTH + 2);
        drive(1'b0, '0, 1'b0);
        drain();

        // Streaming across pointer wrap
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (i >= 3) check("stream_valid", out_valid, 1);
            drive(1'b1, DATA_W'($urandom), 1'b1);
        end
        drain();

        // Random traffic with phased backpressure
        for (int c = 0; c < 10000; c++) begin
            cyc();
            drive(1'($urandom_range(0, 1)), DATA_W'($urandom),
                  ($urandom_range(0, 3) < (c / 1000) % 5));
        end
        drain();

        // Reset with level 37 and a read in flight
        for (int i = 0; i < 38; i++) begin
            cyc();
            drive(1'b1, DATA_W'($urandom), 1'b0);
        end
        cyc();
        check("pre_rst_level38", level, 38);
        drive(1'b0, '0, 1'b1);
        cyc();
        check("pre_rst_level37", level, 37);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_level", level, 0);
        check("async_rst_valid", out_valid, 0);
        cyc();
        reset_n = 1'b1;
        drive(1'b1, 16'h1234, 1'b1);
        cyc();
        drive(1'b0, '0, 1'b1);
        cyc();
        cyc();
        check("post_rst_valid", out_valid, 1);
        check("post_rst_first", out_data, 16'h1234);
        drain();

`ifdef DPRAM_FIFO_FLUSH_EN
        // Flush at level 100 during a push
        for (int i = 0; i < 100; i++) begin
            cyc();
            drive(1'b1, DATA_W'($urandom), 1'b0);
        end
        cyc();
        check("pre_flush_level", level, 100);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        exp_q.delete();
        cyc();
        flush = 1'b0;
        check("flush_level", level, 0);
        check("flush_ready", in_ready, 1);
        check("flush_valid", out_valid, 0);
        drive(1'b1, 16'h0001, 1'b1);
        cyc();
        drive(1'b1, 16'h0002, 1'b1);
        cyc();
        drive(1'b0, '0, 1'b1);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
